// File: rtl/bpm_pos_sim_gen.sv
// ============================================================================
// Module  : bpm_pos_sim_gen
// Brief   : Simulated BPM position frame generator: pattern fill buffer with
//           host write port and a two-cycle read port feeding a DAC word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bpm_pos_sim_gen #(
    parameter int NCH = 360,
    parameter int AW  = 10,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trig,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic [AW-1:0] sel_addr,
    input  logic [DW-1:0] ramp_inc,
    input  logic [DW-1:0] const_val,
    input  logic          host_cs,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          sel_valid,
    output logic [15:0]   dac_out,
    output logic          busy,
    output logic          wr_done,
    output logic          err_range,
    output logic          overrun
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [1:0] c_MODE_CNT   = 2'd0;
    localparam logic [1:0] c_MODE_RAMP  = 2'd1;
    localparam logic [1:0] c_MODE_CONST = 2'd2;
    localparam logic [1:0] c_MODE_HOST  = 2'd3;

    localparam int          c_IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] c_NCH = (AW+1)'(NCH);

    logic [1:0]    r_state;
    logic [1:0]    w_nextState;
    logic [1:0]    r_mode;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_startAddr;
    logic [AW-1:0] r_endAddr;
    logic [c_IW-1:0] r_selAddr;
    logic [DW-1:0] r_constVal;
    logic [DW-1:0] r_acc;
    logic [15:0]   r_frameCnt;
    logic          r_errRange;
    logic          r_overrun;

    logic          w_rangeOk;
    logic          w_selOk;
    logic          w_trigFill;
    logic          w_trigRamp;
    logic          w_hostWr;
    logic          w_we;
    logic [c_IW-1:0] w_wAddr;
    logic [DW-1:0] w_wData;
    logic [15:0]   w_offset;

    logic [DW-1:0] r_mem [NCH];
    logic [DW-1:0] r_rdData1;
    logic          r_rdValid1;
    logic          r_rdSel1;
    logic          r_rdOob1;

    assign w_rangeOk  = (start_addr <= end_addr) && ({1'b0, end_addr} < c_NCH);
    assign w_selOk    = ({1'b0, sel_addr} < c_NCH);
    assign w_trigFill = trig && (r_state == c_IDLE)
                        && ((mode == c_MODE_CNT) || (mode == c_MODE_CONST));
    assign w_trigRamp = trig && (r_state == c_IDLE) && (mode == c_MODE_RAMP);
    assign w_hostWr   = (mode == c_MODE_HOST) && host_cs && host_wr
                        && ({1'b0, host_addr} < c_NCH);
    assign w_offset   = 16'(r_addr - r_startAddr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if ((w_trigFill && w_rangeOk) || (w_trigRamp && w_selOk)) begin
                    w_nextState = c_FILL;
                end
            end
            c_FILL: begin
                if ((r_mode == c_MODE_RAMP) || (r_addr == r_endAddr)) begin
                    w_nextState = c_DONE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != c_IDLE);
        wr_done = (r_state == c_DONE);
        w_we    = 1'b0;
        w_wAddr = c_IW'(r_addr);
        w_wData = r_constVal;
        case (r_state)
            c_IDLE: begin
                if (w_hostWr) begin
                    w_we    = 1'b1;
                    w_wAddr = c_IW'(host_addr);
                    w_wData = host_data;
                end
            end
            c_FILL: begin
                w_we = 1'b1;
                if (r_mode == c_MODE_RAMP) begin
                    w_wAddr = r_selAddr;
                    w_wData = r_acc;
                end else if (r_mode == c_MODE_CNT) begin
                    w_wData = DW'({r_frameCnt, w_offset});
                end
            end
            default: ;
        endcase
    end

    // Frame parameters are captured only on an accepted trigger, so live
    // input changes during a fill cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= c_MODE_CNT;
            r_addr      <= '0;
            r_startAddr <= '0;
            r_endAddr   <= '0;
            r_selAddr   <= '0;
            r_constVal  <= '0;
            r_acc       <= '0;
            r_frameCnt  <= '0;
            r_errRange  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_errRange <= (w_trigFill && !w_rangeOk) || (w_trigRamp && !w_selOk);
            r_overrun  <= trig && (r_state != c_IDLE);
            if ((r_state == c_IDLE) && (w_nextState == c_FILL)) begin
                r_mode      <= mode;
                r_addr      <= start_addr;
                r_startAddr <= start_addr;
                r_endAddr   <= end_addr;
                r_selAddr   <= c_IW'(sel_addr);
                r_constVal  <= const_val;
                if (w_trigRamp) begin
                    r_acc <= r_acc + ramp_inc;
                end
            end else if (r_state == c_FILL) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == c_DONE) begin
                r_frameCnt <= r_frameCnt + 16'd1;
            end
        end
    end

    assign err_range = r_errRange;
    assign overrun   = r_overrun;

    // Buffer is never reset; the read register samples before the write lands.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wAddr] <= w_wData;
        end
        if (rd_en) begin
            r_rdData1 <= r_mem[c_IW'(rd_addr)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdValid1 <= 1'b0;
            r_rdSel1   <= 1'b0;
            r_rdOob1   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            sel_valid  <= 1'b0;
            dac_out    <= '0;
        end else begin
            r_rdValid1 <= rd_en;
            r_rdSel1   <= rd_en && (rd_addr == sel_addr);
            r_rdOob1   <= !({1'b0, rd_addr} < c_NCH);
            rd_valid   <= r_rdValid1;
            sel_valid  <= r_rdSel1;
            if (r_rdValid1) begin
                rd_data <= r_rdOob1 ? '0 : r_rdData1;
            end
            if (r_rdSel1) begin
                dac_out <= r_rdOob1 ? 16'd0 : r_rdData1[15:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bpm_pos_sim_gen.sv
// ============================================================================
// Module  : tb_bpm_pos_sim_gen
// Brief   : Self-checking bench for bpm_pos_sim_gen with a read scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpm_pos_sim_gen;

    localparam int NCH = 360;
    localparam int AW  = 10;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          trig;
    logic [1:0]    mode;
    logic [AW-1:0] start_addr, end_addr, sel_addr;
    logic [DW-1:0] ramp_inc, const_val;
    logic          host_cs, host_wr;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid, sel_valid;
    logic [15:0]   dac_out;
    logic          busy, wr_done, err_range, overrun;

    bpm_pos_sim_gen #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .trig(trig), .mode(mode),
        .start_addr(start_addr), .end_addr(end_addr), .sel_addr(sel_addr),
        .ramp_inc(ramp_inc), .const_val(const_val),
        .host_cs(host_cs), .host_wr(host_wr), .host_addr(host_addr),
        .host_data(host_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .sel_valid(sel_valid),
        .dac_out(dac_out), .busy(busy), .wr_done(wr_done),
        .err_range(err_range), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sel;
    } rdExp_t;

    typedef struct {
        logic [1:0]  vMode;
        int          s;
        int          e;
        int          sel;
        logic [31:0] cval;
        logic        expErr;
        int          expBusy;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    rdExp_t      sb[$];
    logic [31:0] mdl [NCH];
    int          frameNo = 0;
    logic [31:0] accMdl  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Read-side scoreboard: every valid read pops the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got rd_valid=1 data=%0h, expected no read", rd_data);
                end else begin
                    rdExp_t e;
                    e = sb.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                    chk("sel_valid", 64'(sel_valid), 64'(e.sel));
                end
            end else if (sel_valid) begin
                chk("sel_without_rd", 64'(sel_valid), 64'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseTrig;
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic doRead(input int a, input logic [31:0] exp);
        rdExp_t e;
        e.data = exp;
        e.sel  = (AW'(a) == sel_addr);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        sb.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rd_drain: got %0d reads outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Samples from the cycle after the trigger edge until busy drops.
    task automatic runFrame(output int bc, output int dc, output int ec, output int doneAt);
        logic b;
        bc = 0; dc = 0; ec = 0; doneAt = -1;
        for (int i = 0; i < 2000; i++) begin
            b = busy;
            if (b) bc++;
            if (wr_done) begin
                dc++;
                doneAt = bc;
            end
            if (err_range) ec++;
            tick();
            if (!b) return;
        end
        total++;
        bad++;
        $display("FAIL run_frame: got busy=%0b after 2000 cycles, expected 0", busy);
    endtask

    task automatic mdlFill(input logic [1:0] m, input int s, input int e, input logic [31:0] cv);
        for (int a = s; a <= e; a++) begin
            mdl[a] = (m == 2'd2) ? cv : {frameNo[15:0], 16'(a - s)};
        end
        frameNo++;
    endtask

    initial begin
        vec_t vt[7];
        int   bc, dc, ec, da, wd;

        vt[0] = '{2'd0, 10,  5,   7, 32'h0,        1'b1, 0};
        vt[1] = '{2'd0, 0,   360, 7, 32'h0,        1'b1, 0};
        vt[2] = '{2'd2, 5,   5,   7, 32'hCAFE0005, 1'b0, 2};
        vt[3] = '{2'd1, 0,   0,   360, 32'h0,      1'b1, 0};
        vt[4] = '{2'd3, 0,   9,   7, 32'h0,        1'b0, 0};
        vt[5] = '{2'd0, 20,  20,  7, 32'h0,        1'b0, 2};
        vt[6] = '{2'd2, 359, 359, 7, 32'hBEEF0167, 1'b0, 2};

        reset = 1'b1; trig = 1'b0; mode = 2'd0;
        start_addr = '0; end_addr = '0; sel_addr = AW'(7);
        ramp_inc = '0; const_val = '0;
        host_cs = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick(); tick(); tick();
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_flags", 64'({rd_valid, sel_valid, busy, wr_done, err_range, overrun}), 64'd0);
        chk("rst_dac_out", 64'(dac_out), 64'd0);
        reset = 1'b0;
        tick();

        // Host write in mode 3, with explicit two-cycle read latency.
        mode = 2'd3; host_cs = 1'b1; host_wr = 1'b1;
        host_addr = AW'(3); host_data = 32'h12345678;
        tick();
        host_cs = 1'b0; host_wr = 1'b0;
        mdl[3] = 32'h12345678;
        doRead(3, mdl[3]);
        chk("rd_latency_c1", 64'(rd_valid), 64'd0);
        tick();
        chk("rd_latency_c2", 64'(rd_valid), 64'd1);
        drain();
        mode = 2'd0; host_cs = 1'b1; host_wr = 1'b1; host_data = 32'hDEADBEEF;
        tick();
        host_cs = 1'b0; host_wr = 1'b0;
        doRead(3, mdl[3]);
        drain();

        // Full count frame 0..359.
        mode = 2'd0; start_addr = AW'(0); end_addr = AW'(359);
        pulseTrig();
        mode = 2'd2; start_addr = AW'(100); end_addr = AW'(50);
        runFrame(bc, dc, ec, da);
        chk("full_busy_cycles", 64'(bc), 64'd361);
        chk("full_wr_done_cnt", 64'(dc), 64'd1);
        chk("full_wr_done_at", 64'(da), 64'd361);
        mdlFill(2'd0, 0, 359, 32'h0);
        doRead(5, 32'h00000005);
        doRead(359, mdl[359]);
        drain();

        // Second count frame over 0..9 carries frame number 1.
        mode = 2'd0; start_addr = AW'(0); end_addr = AW'(9);
        pulseTrig();
        runFrame(bc, dc, ec, da);
        mdlFill(2'd0, 0, 9, 32'h0);
        doRead(5, 32'h00010005);
        doRead(359, mdl[359]);
        drain();

        // Table of trigger outcomes: range errors, ignored trigs, single-word fills.
        for (int i = 0; i < 7; i++) begin
            mode = vt[i].vMode;
            start_addr = AW'(vt[i].s);
            end_addr   = AW'(vt[i].e);
            sel_addr   = AW'(vt[i].sel);
            const_val  = vt[i].cval;
            pulseTrig();
            chk($sformatf("vec%0d_err", i), 64'(err_range), 64'(vt[i].expErr));
            runFrame(bc, dc, ec, da);
            chk($sformatf("vec%0d_busy", i), 64'(bc), 64'(vt[i].expBusy));
            chk($sformatf("vec%0d_done", i), 64'(dc), (vt[i].expBusy != 0) ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d_err_len", i), 64'(err_range), 64'd0);
            if (vt[i].expBusy != 0) mdlFill(vt[i].vMode, vt[i].s, vt[i].e, vt[i].cval);
        end
        sel_addr = AW'(7);
        doRead(5, mdl[5]);
        doRead(20, mdl[20]);
        doRead(359, mdl[359]);
        doRead(10, mdl[10]);
        drain();

        // Ramp at sel_addr 7, three triggers.
        mode = 2'd1; ramp_inc = 32'h10;
        for (int k = 0; k < 3; k++) begin
            pulseTrig();
            runFrame(bc, dc, ec, da);
            chk($sformatf("ramp%0d_busy", k), 64'(bc), 64'd2);
            accMdl = accMdl + 32'h10;
            mdl[7] = accMdl;
            frameNo++;
            doRead(7, mdl[7]);
            drain();
        end
        tick();
        chk("dac_after_ramp", 64'(dac_out), 64'h0030);
        doRead(5, mdl[5]);
        drain();
        tick(); tick();
        chk("dac_hold_non_sel", 64'(dac_out), 64'h0030);
        chk("rd_data_hold", 64'(rd_data), 64'(mdl[5]));

        // Overrun during a constant fill, plus read-first collision at addr 0.
        mode = 2'd2; start_addr = AW'(0); end_addr = AW'(99); const_val = 32'hA5A5A5A5;
        pulseTrig();
        doRead(0, mdl[0]);
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("overrun_pulse", 64'(overrun), 64'd1);
        tick();
        chk("overrun_len", 64'(overrun), 64'd0);
        runFrame(bc, dc, ec, da);
        chk("overrun_done_cnt", 64'(dc), 64'd1);
        tick(); tick(); tick();
        chk("overrun_no_refill", 64'(busy), 64'd0);
        mdlFill(2'd2, 0, 99, 32'hA5A5A5A5);
        doRead(0, mdl[0]);
        doRead(50, mdl[50]);
        doRead(99, mdl[99]);
        doRead(100, mdl[100]);
        drain();

        // Reset asserted at fill word 50.
        const_val = 32'h5A5A0000;
        pulseTrig();
        wd = 0;
        for (int i = 0; i < 50; i++) begin
            if (wr_done) wd++;
            tick();
        end
        reset = 1'b1;
        #1;
        chk("midrst_rd_data", 64'(rd_data), 64'd0);
        chk("midrst_flags", 64'({rd_valid, sel_valid, busy, wr_done, err_range, overrun}), 64'd0);
        chk("midrst_dac", 64'(dac_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (wr_done) wd++;
            tick();
        end
        chk("midrst_no_wr_done", 64'(wd), 64'd0);
        chk("midrst_idle", 64'(busy), 64'd0);
        for (int a = 0; a < 50; a++) mdl[a] = 32'h5A5A0000;
        frameNo = 0;
        accMdl  = '0;
        doRead(0, mdl[0]);
        doRead(49, mdl[49]);
        doRead(50, mdl[50]);
        doRead(99, mdl[99]);
        drain();

        // Frame counter and accumulator restart from zero after reset.
        mode = 2'd0; start_addr = AW'(30); end_addr = AW'(31);
        pulseTrig();
        runFrame(bc, dc, ec, da);
        mdlFill(2'd0, 30, 31, 32'h0);
        mode = 2'd1; ramp_inc = 32'h10;
        pulseTrig();
        runFrame(bc, dc, ec, da);
        accMdl = accMdl + 32'h10;
        mdl[7] = accMdl;
        doRead(31, 32'h00000001);
        doRead(7, 32'h00000010);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
